// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants and types for the serial-to-parallel receiver and its transmitter.
// COMMA_DEFAULT is the single source of the alignment symbol for both sides of the link.
package serial_paralelo_rx_pkg;

  localparam logic [7:0]  COMMA_DEFAULT      = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEFAULT = 4;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned BIT_CNT_W          = 3;
  localparam int unsigned COMMA_CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              valid;
    logic              active;
    logic              idle;
  } rx_out_t;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial link into the receiver plus its parallel byte outputs.
interface serial_paralelo_rx_if;
  import serial_paralelo_rx_pkg::*;

  logic              data_in;
  logic [BYTE_W-1:0] data_rx;
  logic              valid_rx;
  logic              active;
  logic              idle_out;

  modport master (output data_in, input data_rx, valid_rx, active, idle_out);
  modport slave  (input data_in, output data_rx, valid_rx, active, idle_out);
endinterface

// File: rtl/serial_paralelo_rx_shift8.sv
// rx_shift8: MSB-first shift register with a free-running bit counter.
// realign restarts the counter so the current window becomes a byte boundary reference.
module rx_shift8
  import serial_paralelo_rx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  input  logic              realign,
  output logic [BYTE_W-1:0] window_c,
  output logic              boundary_c
);

  logic [BYTE_W-1:0]    sr;
  logic [BIT_CNT_W-1:0] bit_cnt;

  assign window_c   = {sr[BYTE_W-2:0], data_in};
  assign boundary_c = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

  // Counter wraps naturally 7->0 at its 3-bit width.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr      <= window_c;
      bit_cnt <= realign ? '0 : bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Comma-aligned serial-to-parallel receiver: SEARCH -> ALIGN -> ACTIVE.
// Optional macro RX_RELOCK_EN: a misaligned comma in ACTIVE forces realignment.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA      = COMMA_DEFAULT,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  serial_paralelo_rx_if.slave   rx
);

  localparam logic [COMMA_CNT_W-1:0] LOCK_THR = COMMA_CNT_W'(LOCK_COUNT);

  rx_state_e               state_q, state_d;
  logic [COMMA_CNT_W-1:0]  comma_cnt_q, comma_cnt_d, comma_inc_c;
  rx_out_t                 out_q, out_d;
  logic [BYTE_W-1:0]       window_c;
  logic                    boundary_c;
  logic                    comma_hit_c;
  logic                    realign_c;

  rx_shift8 u_shift (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (rx.data_in),
    .realign    (realign_c),
    .window_c   (window_c),
    .boundary_c (boundary_c)
  );

  assign comma_hit_c = (window_c == COMMA);
  assign comma_inc_c = (comma_cnt_q == '1) ? comma_cnt_q : comma_cnt_q + COMMA_CNT_W'(1);

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    out_d       = out_q;
    realign_c   = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (comma_hit_c) begin
          realign_c   = 1'b1;
          comma_cnt_d = COMMA_CNT_W'(1);
          state_d     = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (boundary_c) begin
          if (comma_hit_c) begin
            comma_cnt_d = comma_inc_c;
            if (comma_inc_c >= LOCK_THR) state_d = ST_ACTIVE;
          end else begin
            comma_cnt_d = '0;
            state_d     = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary_c) begin
          if (!comma_hit_c) begin
            out_d.data  = window_c;
            out_d.valid = 1'b1;
            out_d.idle  = 1'b0;
          end else begin
            out_d.valid = 1'b0;
            out_d.idle  = 1'b1;
          end
        end
`ifdef RX_RELOCK_EN
        else if (comma_hit_c) begin
          // Comma seen off the byte grid: the link slipped, restart alignment here.
          realign_c   = 1'b1;
          comma_cnt_d = COMMA_CNT_W'(1);
          out_d.valid = 1'b0;
          state_d     = ST_ALIGN;
        end
`endif
      end
      default: state_d = ST_SEARCH;
    endcase

    out_d.active = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      comma_cnt_q <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      out_q       <= out_d;
    end
  end

  assign rx.data_rx  = out_q.data;
  assign rx.valid_rx = out_q.valid;
  assign rx.active   = out_q.active;
  assign rx.idle_out = out_q.idle;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: bit-stream scenarios checked cycle by cycle
// against a stream-scanning reference model of the comma alignment rules.
module tb_serial_paralelo_rx;

  localparam logic [7:0] C_COMMA = 8'hBC;
  localparam int         C_LOCK  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_paralelo_rx_if bus ();

  serial_paralelo_rx dut (
    .clk_32f (clk),
    .reset   (rst),
    .rx      (bus)
  );

  always #5 clk = ~clk;

  bit          stim[$];
  logic [10:0] obs[$];
  logic [10:0] expv[$];
  logic [7:0]  ed[];
  logic        ev[];
  logic        ea[];
  logic        ei[];

  function automatic void push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
  endfunction

  // Eight most recent stream bits ending at cycle c; bits before the stream are zero.
  function automatic logic [7:0] win(input int c);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = c - 7 + k;
      w = {w[6:0], (idx >= 0) ? logic'(stim[idx]) : 1'b0};
    end
    return w;
  endfunction

  function automatic void set_from(input int c, input int field, input logic [7:0] v);
    for (int k = c; k < stim.size(); k++) begin
      case (field)
        0: ed[k] = v;
        1: ev[k] = v[0];
        2: ea[k] = v[0];
        default: ei[k] = v[0];
      endcase
    end
  endfunction

  // Scan the stream: find a comma, demand commas every 8 bits until locked, then
  // decode every 8th window as data or idle.
  function automatic void run_model();
    int n, pos, i, j, k, relock;
    bit locked, failed;
    n = stim.size();
    ed = new[n]; ev = new[n]; ea = new[n]; ei = new[n];
    for (int c = 0; c < n; c++) begin
      ed[c] = '0; ev[c] = 1'b0; ea[c] = 1'b0; ei[c] = 1'b0;
    end
    pos = 0;
    i   = -1;
    while (1) begin
      if (i < 0) begin
        i = pos;
        while (i < n && win(i) != C_COMMA) i++;
        if (i >= n) break;
      end
      k = 1; j = i + 8; locked = 0; failed = 0;
      while (j < n) begin
        if (win(j) == C_COMMA) begin
          k++;
          if (k >= C_LOCK) begin locked = 1; break; end
        end else begin
          failed = 1; break;
        end
        j += 8;
      end
      if (failed) begin pos = j + 1; i = -1; continue; end
      if (!locked) break;
      set_from(j, 2, 8'd1);
      relock = -1;
      for (int c = j + 1; c < n; c++) begin
        if ((c - j) % 8 == 0) begin
          if (win(c) != C_COMMA) begin
            set_from(c, 0, win(c)); set_from(c, 1, 8'd1); set_from(c, 3, 8'd0);
          end else begin
            set_from(c, 1, 8'd0); set_from(c, 3, 8'd1);
          end
        end
`ifdef RX_RELOCK_EN
        else if (win(c) == C_COMMA) begin
          relock = c; break;
        end
`endif
      end
      if (relock < 0) break;
      set_from(relock, 2, 8'd0); set_from(relock, 1, 8'd0);
      i = relock;
    end
    expv.delete();
    for (int c = 0; c < n; c++) expv.push_back({ed[c], ev[c], ea[c], ei[c]});
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_stream();
    obs.delete();
    foreach (stim[c]) begin
      bus.data_in = stim[c];
      @(posedge clk); #1;
      obs.push_back({bus.data_rx, bus.valid_rx, bus.active, bus.idle_out});
    end
  endtask

  task automatic test_reset();
    logic [10:0] o;
    stim.delete();
    for (int b = 0; b < 4; b++) push_byte(C_COMMA);
    push_byte(8'h66);
    do_reset();
    drive_stream();
    #2 rst = 1'b1;
    #1;
    o = {bus.data_rx, bus.valid_rx, bus.active, bus.idle_out};
    checks++;
    if (o !== 11'h000) begin
      errors++; $display("FAIL reset_outputs: got %03h expected 000", o);
    end
    repeat (3) @(posedge clk);
    #1;
    o = {bus.data_rx, bus.valid_rx, bus.active, bus.idle_out};
    checks++;
    if (o !== 11'h000) begin
      errors++; $display("FAIL reset_held: got %03h expected 000", o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_lock();
    logic [10:0] o;
    stim.delete();
    for (int b = 0; b < 4; b++) push_byte(C_COMMA);
    push_byte(8'hA5);
    push_byte(C_COMMA);
    do_reset();
    drive_stream();
    run_model();
    for (int c = 0; c < obs.size(); c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL basic_lock cycle %0d: got %03h expected %03h", c, obs[c], expv[c]);
      end
    end
    o = obs[30];
    checks++;
    if (o[1] !== 1'b0) begin errors++; $display("FAIL basic_active_early: got %b expected 0", o[1]); end
    o = obs[31];
    checks++;
    if (o[1] !== 1'b1) begin errors++; $display("FAIL basic_active_rise: got %b expected 1", o[1]); end
    for (int c = 39; c <= 46; c++) begin
      o = obs[c];
      checks++;
      if (o !== {8'hA5, 3'b110}) begin
        errors++; $display("FAIL basic_a5_hold cycle %0d: got %03h expected %03h", c, o, {8'hA5, 3'b110});
      end
    end
  endtask

  task automatic test_offset_lock();
    logic [10:0] o;
    logic [2:0]  junk;
    junk = 3'($urandom_range(0, 7));
    stim.delete();
    for (int k = 2; k >= 0; k--) stim.push_back(junk[k]);
    for (int b = 0; b < 4; b++) push_byte(C_COMMA);
    push_byte(8'h3C);
    push_byte(8'h81);
    do_reset();
    drive_stream();
    run_model();
    for (int c = 0; c < obs.size(); c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL offset_lock cycle %0d: got %03h expected %03h", c, obs[c], expv[c]);
      end
    end
    o = obs[42];
    checks++;
    if (o !== {8'h3C, 3'b110}) begin
      errors++; $display("FAIL offset_3c: got %03h expected %03h", o, {8'h3C, 3'b110});
    end
  endtask

  task automatic test_false_lock();
    logic [10:0] o;
    stim.delete();
    push_byte(C_COMMA); push_byte(C_COMMA); push_byte(8'h11);
    for (int b = 0; b < 4; b++) push_byte(C_COMMA);
    push_byte(8'hFF);
    push_byte(C_COMMA);
    do_reset();
    drive_stream();
    run_model();
    for (int c = 0; c < obs.size(); c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL false_lock cycle %0d: got %03h expected %03h", c, obs[c], expv[c]);
      end
    end
    o = obs[54];
    checks++;
    if (o[1] !== 1'b0) begin errors++; $display("FAIL false_lock_not_active: got %b expected 0", o[1]); end
    o = obs[63];
    checks++;
    if (o !== {8'hFF, 3'b110}) begin
      errors++; $display("FAIL false_lock_ff: got %03h expected %03h", o, {8'hFF, 3'b110});
    end
  endtask

  task automatic test_idle_random();
    logic [10:0] o;
    logic [7:0]  b;
    stim.delete();
    for (int k = 0; k < 4; k++) push_byte(C_COMMA);
    push_byte(8'hA5);
    push_byte(C_COMMA);
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) b = C_COMMA;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == C_COMMA) b = 8'h5A;
      end
      push_byte(b);
    end
    do_reset();
    drive_stream();
    run_model();
    for (int c = 0; c < obs.size(); c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL idle_random cycle %0d: got %03h expected %03h", c, obs[c], expv[c]);
      end
    end
    o = obs[47];
    checks++;
    if (o !== {8'hA5, 3'b011}) begin
      errors++; $display("FAIL idle_hold_a5: got %03h expected %03h", o, {8'hA5, 3'b011});
    end
  endtask

  task automatic test_reset_in_active();
    logic [10:0] o;
    stim.delete();
    for (int k = 0; k < 4; k++) push_byte(C_COMMA);
    push_byte(8'hC3);
    for (int k = 0; k < 3; k++) stim.push_back(1'($urandom_range(0, 1)));
    do_reset();
    drive_stream();
    o = obs[obs.size() - 1];
    checks++;
    if (o !== {8'hC3, 3'b110}) begin
      errors++; $display("FAIL pre_reset_active: got %03h expected %03h", o, {8'hC3, 3'b110});
    end
    #2 rst = 1'b1;
    #1;
    o = {bus.data_rx, bus.valid_rx, bus.active, bus.idle_out};
    checks++;
    if (o !== 11'h000) begin
      errors++; $display("FAIL async_reset_clear: got %03h expected 000", o);
    end
    @(posedge clk); #1 rst = 1'b0;
    stim.delete();
    for (int k = 0; k < 3; k++) push_byte(C_COMMA);
    push_byte(8'h5A);
    for (int k = 0; k < 4; k++) push_byte(C_COMMA);
    push_byte(8'h77);
    drive_stream();
    run_model();
    for (int c = 0; c < obs.size(); c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL reset_relock cycle %0d: got %03h expected %03h", c, obs[c], expv[c]);
      end
    end
    o = obs[62];
    checks++;
    if (o[1] !== 1'b0) begin errors++; $display("FAIL relock_needs_fresh: got %b expected 0", o[1]); end
    o = obs[63];
    checks++;
    if (o[1] !== 1'b1) begin errors++; $display("FAIL relock_active: got %b expected 1", o[1]); end
  endtask

  task automatic test_misaligned_comma();
    logic [10:0] o;
    stim.delete();
    for (int k = 0; k < 4; k++) push_byte(C_COMMA);
    push_byte(8'hA5);
    stim.push_back(1'b0); stim.push_back(1'b0);
    for (int k = 0; k < 4; k++) push_byte(C_COMMA);
    push_byte(8'h5A);
    push_byte(8'h00);
    do_reset();
    drive_stream();
    run_model();
    for (int c = 0; c < obs.size(); c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL misaligned cycle %0d: got %03h expected %03h", c, obs[c], expv[c]);
      end
    end
`ifdef RX_RELOCK_EN
    o = obs[49];
    checks++;
    if (o[1] !== 1'b0) begin errors++; $display("FAIL relock_drop: got %b expected 0", o[1]); end
    o = obs[72];
    checks++;
    if (o[1] !== 1'b0) begin errors++; $display("FAIL relock_align: got %b expected 0", o[1]); end
    o = obs[81];
    checks++;
    if (o !== {8'h5A, 3'b110}) begin
      errors++; $display("FAIL relock_data: got %03h expected %03h", o, {8'h5A, 3'b110});
    end
`else
    o = obs[49];
    checks++;
    if (o[1] !== 1'b1) begin errors++; $display("FAIL no_relock_active: got %b expected 1", o[1]); end
`endif
    o = obs[73];
    checks++;
    if (o[1] !== 1'b1) begin errors++; $display("FAIL misaligned_active_end: got %b expected 1", o[1]); end
  endtask

  initial begin
    bus.data_in = 1'b0;
    test_reset();
    test_basic_lock();
    test_offset_lock();
    test_false_lock();
    test_idle_random();
    test_reset_in_active();
    test_misaligned_comma();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC: alignment/idle symbol sent by the transmitter when no lane is valid.
REQ-002 Parameter LOCK_COUNT, default 4: aligned commas required to enter ACTIVE (legal range 2..15).
REQ-003 clk_32f  input  1  single bit clock; the block has one clock only, and all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  1  serial stream, MSB first, one bit per clk_32f (the transmitter's data_out).
REQ-006 data_rx  output  8  last deserialized non-comma byte.
REQ-007 valid_rx  output  1  high while data_rx holds a byte received in ACTIVE.
REQ-008 active  output  1  high while the FSM is in ACTIVE.
REQ-009 idle_out  output  1  high while the last byte received in ACTIVE was COMMA.

Function
REQ-010 The block SHALL shift data_in into an 8-bit register each cycle; the window is {sr[6:0], data_in}.
REQ-011 The block SHALL use a 3-bit bit counter bit_cnt; a byte boundary is a cycle with bit_cnt==7, and the counter wraps 7->0.
REQ-012 FSM states are SEARCH, ALIGN and ACTIVE; the encoding is 2 bits.
REQ-013 In SEARCH, a window==COMMA on any cycle SHALL set bit_cnt to 0, set comma_cnt to 1, and go to ALIGN.
REQ-014 In ALIGN, at each boundary, window==COMMA SHALL increment comma_cnt, and reaching LOCK_COUNT SHALL go to ACTIVE.
REQ-015 In ALIGN, at a boundary, window!=COMMA SHALL clear comma_cnt and return to SEARCH.
REQ-016 In ACTIVE, at each boundary, window!=COMMA SHALL load data_rx=window, set valid_rx=1 and clear idle_out, all on that same edge.
REQ-017 In ACTIVE, at each boundary, window==COMMA SHALL hold data_rx, clear valid_rx and set idle_out.
REQ-018 Outputs SHALL change only at boundary edges and hold for 8 cycles; the latency is 0 cycles after the byte's last bit is sampled.
REQ-019 active SHALL rise on the edge that enters ACTIVE; the first data byte SHALL follow on the next boundary.
REQ-020 comma_cnt SHALL be 4 bits and saturate; it is not used in ACTIVE.
REQ-021 ACTIVE SHALL be left only by reset, or by relock when configured (REQ-025).

Reset
REQ-022 While reset is high: state=SEARCH, sr=0, bit_cnt=0, comma_cnt=0, data_rx=8'h00, valid_rx=0, active=0, idle_out=0.
REQ-023 Reset asserted mid-byte or in ACTIVE SHALL discard the partial byte; after release, alignment restarts from SEARCH.
REQ-024 The first edge after reset release SHALL sample data_in normally.

Configuration
REQ-025 Macro RX_RELOCK_EN: when defined, in ACTIVE a window==COMMA at a non-boundary cycle (misaligned) SHALL set bit_cnt=0, comma_cnt=1, valid_rx=0, active=0, and go to ALIGN.
REQ-026 Without RX_RELOCK_EN, misaligned commas in ACTIVE SHALL be ignored, and that logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the COMMA default, the LOCK_COUNT default and the FSM state constants; the transmitter side SHALL reuse COMMA from it.
REQ-028 One sub-module SHALL exist: rx_shift8 (the shift register plus bit_cnt with a realign input). The FSM and output registers live in serial_paralelo_rx.

Verification
REQ-029 Reset, then 4 aligned BC bytes, then 8'hA5 -> active=1 after the 4th BC; data_rx=A5 and valid_rx=1 at the next boundary, held 8 cycles.
REQ-030 3 junk bits, then 4 BC, then 8'h3C -> lock with 3-bit offset; data_rx=3C, valid_rx=1.
REQ-031 BC, BC, 8'h11, BC x4, 8'hFF -> return to SEARCH after 8'h11; active only after the later 4 BC; data_rx=FF.
REQ-032 ACTIVE, then BC -> valid_rx=0, idle_out=1, data_rx unchanged (previous byte).
REQ-033 reset pulse mid-byte in ACTIVE -> all outputs 0 immediately (asynchronously); relock requires 4 fresh BC.
REQ-034 RX_RELOCK_EN: ACTIVE, then BC shifted by 2 bits -> active=0 and state ALIGN; with 3 more aligned BC, active=1 again. Without the macro -> active stays 1.
